onchip_mem_burst_slave: RTL and testbench



---
 rtl/onchip_mem_pkg.sv | 26 ++
 rtl/onchip_mem_ram_core.sv | 36 +++
 rtl/onchip_mem_burst_slave.sv | 175 +++++++++++++++++
 tb/tb_onchip_mem_burst_slave.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the on-chip memory burst slave.
package onchip_mem_pkg;

  typedef enum logic {IDLE = 1'b0, RBURST = 1'b1} state_e;

  localparam int WM_DEBUG_ONLY = 0;
  localparam int WM_ALWAYS     = 1;
  localparam int PAR_MAX_BYTES = 128;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Even parity per byte: the stored bit makes each 9-bit lane have an even count of ones.
  function automatic logic [PAR_MAX_BYTES-1:0] parity_vec(input logic [PAR_MAX_BYTES*8-1:0] data);
    logic [PAR_MAX_BYTES-1:0] par;
    for (int i = 0; i < PAR_MAX_BYTES; i++) par[i] = ^data[i*8 +: 8];
    return par;
  endfunction

endpackage

// File: rtl/onchip_mem_ram_core.sv
// Inferred single-port synchronous RAM with per-lane write enables and a registered output.
// Each lane is LANE_W bits wide so an optional parity bit travels with its byte.
module onchip_mem_ram_core #(
  parameter int LANES     = 4,
  parameter int LANE_W    = 8,
  parameter int DEPTH     = 8192,
  parameter int ADDR_W    = 13,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en_i,
  input  logic                     rd_i,
  input  logic [LANES-1:0]         we_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [LANES*LANE_W-1:0]  wdata_i,
  output logic [LANES*LANE_W-1:0]  rdata_o
);

  logic [LANES*LANE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (we_i[i]) mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
      end
    end
  end

  // The output register only loads on reads, so it holds the last beat between bursts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_o <= '0;
    else if (en_i && rd_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/onchip_mem_burst_slave.sv
// Avalon-MM on-chip RAM slave with pipelined incrementing read bursts.
// Optional per-byte parity storage and checking when ONCHIP_MEM_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | accepting commands; a read issues its first address here
// RBURST | issuing the remaining burst addresses, waitrequest held high
module onchip_mem_burst_slave
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8192,
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 2,
  parameter int BURST_W      = 4,
  parameter int WRITE_MODE   = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [BURST_W-1:0]  burstcount,
  input  logic                debugaccess,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid
`ifdef ONCHIP_MEM_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int NB = DATA_W / 8;
  localparam int IW = clog2(DEPTH);
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BURST_W-1:0]   cnt_q;
  logic                 v1_q, oor1_q;

  logic                 accept, rd_acc, wr_acc, wr_ok, issue, in_range;
  logic [ADDR_W-1:0]    next_addr, issue_addr;
  logic [IW-1:0]        ram_addr;
  logic [NB*LANE_W-1:0] wdata_ram, rdata_ram;
  logic [DATA_W-1:0]    rd_data, beat_data;

  assign waitrequest = (state_q == RBURST);
  assign accept      = clken & chipselect & ~waitrequest;
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign next_addr   = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
  assign issue       = rd_acc | (waitrequest & clken);
  assign issue_addr  = waitrequest ? next_addr : address;
  assign in_range    = {1'b0, issue_addr} < DEPTH_X;
  assign ram_addr    = in_range ? issue_addr[IW-1:0] : '0;
  assign wr_ok       = wr_acc & in_range &
                       ((WRITE_MODE == WM_ALWAYS) | ((WRITE_MODE == WM_DEBUG_ONLY) & debugaccess));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (rd_acc) begin
            addr_q <= address;
            cnt_q  <= (burstcount == '0) ? '0 : burstcount - 1'b1;
            if (burstcount > BURST_W'(1)) state_q <= RBURST;
          end
        end
        RBURST: begin
          addr_q <= next_addr;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == BURST_W'(1)) state_q <= IDLE;
        end
      endcase
    end
  end

  // Stage 1 tracks the beat sitting in the RAM output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      oor1_q <= 1'b0;
    end else if (clken) begin
      v1_q <= issue;
      if (issue) oor1_q <= ~in_range;
    end
  end

`ifdef ONCHIP_MEM_PARITY_EN
  logic [PAR_MAX_BYTES-1:0] wpar_w, rpar_w;
  logic [NB-1:0]            rd_par;
  assign wpar_w = parity_vec((PAR_MAX_BYTES*8)'(writedata));
  assign rpar_w = parity_vec((PAR_MAX_BYTES*8)'(rd_data));
`endif

  always_comb begin
    wdata_ram = '0;
    rd_data   = '0;
`ifdef ONCHIP_MEM_PARITY_EN
    rd_par    = '0;
`endif
    for (int i = 0; i < NB; i++) begin
      wdata_ram[i*LANE_W +: 8] = writedata[i*8 +: 8];
      rd_data[i*8 +: 8]        = rdata_ram[i*LANE_W +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
      wdata_ram[i*LANE_W + 8]  = wpar_w[i];
      rd_par[i]                = rdata_ram[i*LANE_W + 8];
`endif
    end
  end

  assign beat_data = oor1_q ? '0 : rd_data;

  onchip_mem_ram_core #(
    .LANES     (NB),
    .LANE_W    (LANE_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (IW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (clken),
    .rd_i    (issue),
    .we_i    (wr_ok ? byteenable : '0),
    .addr_i  (ram_addr),
    .wdata_i (wdata_ram),
    .rdata_o (rdata_ram)
  );

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign readdata      = beat_data;
      assign readdatavalid = v1_q & clken;
    end else begin : g_lat2
      logic              v2_q;
      logic [DATA_W-1:0] rd2_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2_q  <= 1'b0;
          rd2_q <= '0;
        end else if (clken) begin
          v2_q <= v1_q;
          if (v1_q) rd2_q <= beat_data;
        end
      end
      assign readdata      = rd2_q;
      assign readdatavalid = v2_q & clken;
    end
  endgenerate

`ifdef ONCHIP_MEM_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err <= 1'b0;
    else if (clken && v1_q && !oor1_q && (rpar_w[NB-1:0] != rd_par)) parity_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_onchip_mem_burst_slave.sv
// Directed bench: dut0 = defaults (latency 2, writes always allowed, DEPTH 8192);
// dut1 = latency 1, debug-only writes, DEPTH 100, driven by the same bus.
module tb_onchip_mem_burst_slave;

  localparam int AW = 13;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              reset_n, clken, chipselect, read, write, debugaccess;
  logic [AW-1:0]     address;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [BW-1:0]     burstcount;
  logic              wr0, rdv0, wr1, rdv1;
  logic [31:0]       rd0, rd1;
`ifdef ONCHIP_MEM_PARITY_EN
  logic              perr0, perr1;
`endif

  int          n_vec = 0, n_bad = 0;
  int          cyc = 0, acc = 0, n_wait0 = 0, stall_rdv = 0;
  int          base0 = 0, base1 = 0, wbase0 = 0;
  logic [31:0] q0[$], q1[$];
  int          s0[$], s1[$];

  onchip_mem_burst_slave #(.DATA_W(32), .DEPTH(8192), .ADDR_W(AW), .READ_LATENCY(2),
                           .BURST_W(BW), .WRITE_MODE(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
    .burstcount(burstcount), .debugaccess(debugaccess), .waitrequest(wr0),
    .readdata(rd0), .readdatavalid(rdv0)
`ifdef ONCHIP_MEM_PARITY_EN
    , .parity_err(perr0)
`endif
  );

  onchip_mem_burst_slave #(.DATA_W(32), .DEPTH(100), .ADDR_W(AW), .READ_LATENCY(1),
                           .BURST_W(BW), .WRITE_MODE(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
    .burstcount(burstcount), .debugaccess(debugaccess), .waitrequest(wr1),
    .readdata(rd1), .readdatavalid(rdv1)
`ifdef ONCHIP_MEM_PARITY_EN
    , .parity_err(perr1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stamp = index of the clock edge at which a master samples the beat.
  always @(negedge clk) begin
    if (rdv0) begin q0.push_back(rd0); s0.push_back(cyc + 1); end
    if (rdv1) begin q1.push_back(rd1); s1.push_back(cyc + 1); end
    if (wr0) n_wait0++;
    if (!clken && (rdv0 || rdv1)) stall_rdv++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat0(input int i);
    return (base0 + i < q0.size()) ? q0[base0 + i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] beat1(input int i);
    return (base1 + i < q1.size()) ? q1[base1 + i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int stamp0(input int i);
    return (base0 + i < s0.size()) ? s0[base0 + i] : -1000;
  endfunction
  function automatic int stamp1(input int i);
    return (base1 + i < s1.size()) ? s1[base1 + i] : -1000;
  endfunction

  task automatic wr_cmd(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic dbg);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be; debugaccess = dbg;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; byteenable = '0; debugaccess = 1'b0;
  endtask

  task automatic rd_cmd(input logic [AW-1:0] a, input logic [BW-1:0] bc);
    base0 = q0.size(); base1 = q1.size(); wbase0 = n_wait0;
    chipselect = 1'b1; read = 1'b1; address = a; burstcount = bc;
    @(posedge clk); #1;
    acc = cyc;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pre[4];
    pre[0] = 32'hC0DE0000; pre[1] = 32'hC0DE0001; pre[2] = 32'hC0DE0002; pre[3] = 32'hC0DE0003;

    reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    debugaccess = 1'b0; address = '0; byteenable = '0; writedata = '0; burstcount = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_wait0", wr0, 0);  chk("rst_rdv0", rdv0, 0);  chk("rst_rdata0", rd0, 0);
    chk("rst_wait1", wr1, 0);  chk("rst_rdv1", rdv1, 0);  chk("rst_rdata1", rd1, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single write then read, latency 2 on dut0 and 1 on dut1
    wr_cmd(13'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    rd_cmd(13'd5, 4'd1); drain(6);
    chk("t1_nbeats0", q0.size() - base0, 1);
    chk("t1_data0", beat0(0), 32'hDEADBEEF);
    chk("t1_lat0", stamp0(0) - acc, 2);
    chk("t1_nbeats1", q1.size() - base1, 1);
    chk("t1_lat1", stamp1(0) - acc, 1);

    // Partial byte write and zero byteenable
    wr_cmd(13'd9, 32'h11223344, 4'hF, 1'b0);
    wr_cmd(13'd9, 32'h0000AA00, 4'b0010, 1'b0);
    rd_cmd(13'd9, 4'd1); drain(6);
    chk("t2_be_merge", beat0(0), 32'h1122AA44);
    wr_cmd(13'd9, 32'hFFFFFFFF, 4'b0000, 1'b1);
    rd_cmd(13'd9, 4'd1); drain(6);
    chk("t2_be_zero", beat0(0), 32'h1122AA44);

    // burstcount 0 behaves as a single beat
    rd_cmd(13'd5, 4'd0); drain(6);
    chk("t2_bc0_nbeats", q0.size() - base0, 1);
    chk("t2_bc0_wait", n_wait0 - wbase0, 0);
    chk("t2_bc0_data", beat0(0), 32'hDEADBEEF);

    // Wrapping burst of 4 from DEPTH-2 on dut0; dut1 sees out-of-range then 0,1
    wr_cmd(13'd8190, pre[0], 4'hF, 1'b1);
    wr_cmd(13'd8191, pre[1], 4'hF, 1'b1);
    wr_cmd(13'd0,    pre[2], 4'hF, 1'b1);
    wr_cmd(13'd1,    pre[3], 4'hF, 1'b1);
    rd_cmd(13'd8190, 4'd4); drain(10);
    chk("t3_wait", n_wait0 - wbase0, 3);
    chk("t3_nbeats0", q0.size() - base0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_beat0_%0d", i), beat0(i), pre[i]);
    chk("t3_span0", stamp0(3) - stamp0(0), 3);
    chk("t3_lat0", stamp0(0) - acc, 2);
    chk("t3_nbeats1", q1.size() - base1, 4);
    chk("t3_oor_a", beat1(0), 32'h0);
    chk("t3_oor_b", beat1(1), 32'h0);
    chk("t3_wrap_a", beat1(2), pre[2]);
    chk("t3_wrap_b", beat1(3), pre[3]);
    chk("t3_lat1", stamp1(0) - acc, 1);

    // Debug-only write policy on dut1
    wr_cmd(13'd3, 32'h00000077, 4'hF, 1'b1);
    wr_cmd(13'd3, 32'h00000055, 4'hF, 1'b0);
    rd_cmd(13'd3, 4'd1); drain(6);
    chk("t4_always_wr", beat0(0), 32'h00000055);
    chk("t4_blocked_wr", beat1(0), 32'h00000077);
    wr_cmd(13'd3, 32'h00000066, 4'hF, 1'b1);
    rd_cmd(13'd3, 4'd1); drain(6);
    chk("t4_dbg_wr0", beat0(0), 32'h00000066);
    chk("t4_dbg_wr1", beat1(0), 32'h00000066);

    // clken low for 3 cycles after the first beat of a 4-beat burst
    for (int i = 0; i < 4; i++) wr_cmd(AW'(20 + i), 32'h20000000 + i, 4'hF, 1'b1);
    rd_cmd(13'd20, 4'd4);
    @(posedge clk); @(posedge clk); #1;
    clken = 1'b0;
    repeat (3) @(posedge clk); #1;
    clken = 1'b1;
    drain(8);
    chk("t5_nbeats", q0.size() - base0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_beat_%0d", i), beat0(i), 32'h20000000 + i);
    chk("t5_span", stamp0(3) - stamp0(0) + 1, 7);
    chk("t5_wait", n_wait0 - wbase0, 6);
    chk("t5_stall_rdv", stall_rdv, 0);

    // Reset in the middle of an 8-beat burst
    rd_cmd(13'd0, 4'd8);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("t6_nbeats", q0.size() - base0, 2);
    chk("t6_beat1", beat0(1), pre[3]);
    chk("t6_rst_wait", wr0, 0);
    chk("t6_rst_rdv", rdv0, 0);
    chk("t6_rst_rdata", rd0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd_cmd(13'd0, 4'd1); drain(6);
    chk("t6_after_nbeats", q0.size() - base0, 1);
    chk("t6_after_data0", beat0(0), pre[2]);
    chk("t6_after_data1", beat1(0), pre[2]);

`ifdef ONCHIP_MEM_PARITY_EN
    chk("par_clean", perr0, 0);
    dut0.u_ram.mem_q[0][3] = ~dut0.u_ram.mem_q[0][3];
    rd_cmd(13'd0, 4'd1); drain(6);
    chk("par_set", perr0, 1);
    chk("par_other", perr1, 0);
    drain(4);
    chk("par_sticky", perr0, 1);
    reset_n = 1'b0;
    #1;
    chk("par_rst", perr0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
